csr_interrupt_ctrl: RTL and testbench

Machine-mode CSR file and interrupt controller for the pipelined RV32 core, located in the memory/writeback (MW) stage. It samples external and timer interrupt requests and holds mstatus, mie, mip, mtvec, mepc and mcause. It decides trap entry and mret return, and drives the `interrupt` code and PC redirect consumed by the hazard/flush logic and the fetch stage. All CSR state updates happen at the clock edge that ends the deciding cycle.

---
 rtl/csr_interrupt_ctrl_if.sv | 29 ++
 rtl/csr_interrupt_ctrl.sv | 140 ++++++++++++++
 tb/tb_csr_interrupt_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_interrupt_ctrl_if.sv
// csr_interrupt_ctrl_if
// Connects the MW-stage pipeline to the machine-mode CSR / interrupt controller.
//   master : pipeline side. Drives instruction info and CSR access; receives
//            read data, interrupt code and PC redirect.
//   slave  : controller side.
interface csr_interrupt_ctrl_if;
  logic        valid_mw;
  logic [31:0] pc_mw;
  logic        is_mret;
  logic        csr_wr;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [1:0]  interrupt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        in_handler;

  modport master (
    output valid_mw, pc_mw, is_mret, csr_wr, csr_op, csr_addr, csr_wdata,
    input  csr_rdata, interrupt, redirect, redirect_pc, in_handler
  );

  modport slave (
    input  valid_mw, pc_mw, is_mret, csr_wr, csr_op, csr_addr, csr_wdata,
    output csr_rdata, interrupt, redirect, redirect_pc, in_handler
  );
endinterface

// File: rtl/csr_interrupt_ctrl.sv
// csr_interrupt_ctrl
// Machine-mode CSR file and interrupt controller sitting in the MW stage.
// Holds mstatus, mie, mip, mtvec, mepc and mcause. Decides trap entry and
// mret return, and produces the PC redirect for fetch.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   irq_ext          : asynchronous external interrupt level
//   irq_timer        : asynchronous timer interrupt level
//   bus (slave)      : MW-stage instruction / CSR access, and the outputs
//                      csr_rdata, interrupt, redirect, redirect_pc, in_handler
module csr_interrupt_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 irq_ext,
  input  logic                 irq_timer,
  csr_interrupt_ctrl_if.slave  bus
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_MASK  = 32'hFFFF_FFFC;

  typedef enum logic {IDLE = 1'b0, HANDLER = 1'b1} state_t;

  state_t      state;
  logic        st_mie, st_mpie;
  logic        en_mtie, en_meie;
  logic        ext_sync_p0, tim_sync_p0;
  logic        mip_meip, mip_mtip;
  logic [31:0] mtvec, mepc, mcause;

  logic [31:0] mstatus_val, mie_val, mip_val, rdata, new_val, vec_offset;
  logic        pend_ext, pend_tim, take, ret, wr_en;
  logic [3:0]  cause;

  function automatic logic [31:0] csr_alu(input logic [1:0]  op,
                                          input logic [31:0] old,
                                          input logic [31:0] wdata);
    case (op)
      2'b01:   return wdata;
      2'b10:   return old | wdata;
      2'b11:   return old & ~wdata;
      default: return old;
    endcase
  endfunction

  assign mstatus_val = {24'd0, st_mpie, 3'd0, st_mie, 3'd0};
  assign mie_val     = {20'd0, en_meie, 3'd0, en_mtie, 7'd0};
  assign mip_val     = {20'd0, mip_meip, 3'd0, mip_mtip, 7'd0};

  always_comb begin
    rdata = 32'd0;
    case (bus.csr_addr)
      ADDR_MSTATUS: rdata = mstatus_val;
      ADDR_MIE:     rdata = mie_val;
      ADDR_MIP:     rdata = mip_val;
      ADDR_MTVEC:   rdata = mtvec;
      ADDR_MEPC:    rdata = mepc;
      ADDR_MCAUSE:  rdata = mcause;
      default:      rdata = 32'd0;
    endcase
  end

  assign pend_ext = mip_meip & en_meie;
  assign pend_tim = mip_mtip & en_mtie;
  assign take     = bus.valid_mw & st_mie & (pend_ext | pend_tim);
  assign cause    = pend_ext ? 4'd11 : 4'd7;
  // An instruction that traps does not retire, so neither its mret nor its
  // CSR write may take effect; mret also suppresses a (malformed) write.
  assign ret      = bus.valid_mw & bus.is_mret & ~take;
  assign wr_en    = bus.valid_mw & bus.csr_wr & (bus.csr_op != 2'b00) & ~take & ~ret;
  assign new_val  = csr_alu(bus.csr_op, rdata, bus.csr_wdata);

  assign vec_offset = mtvec[0] ? {26'd0, cause, 2'b00} : 32'd0;

  assign bus.csr_rdata   = rdata;
  assign bus.interrupt   = take ? 2'b01 : (ret ? 2'b10 : 2'b00);
  assign bus.redirect    = take | ret;
  assign bus.redirect_pc = take ? ({mtvec[31:2], 2'b00} + vec_offset) : mepc;
  assign bus.in_handler  = (state == HANDLER);

  // Single state/CSR register stage; the second synchronizer flop is mip itself
  // so a request shows in mip two edges after it is first sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      st_mie      <= 1'b0;
      st_mpie     <= 1'b0;
      en_mtie     <= 1'b0;
      en_meie     <= 1'b0;
      ext_sync_p0 <= 1'b0;
      tim_sync_p0 <= 1'b0;
      mip_meip    <= 1'b0;
      mip_mtip    <= 1'b0;
      mtvec       <= RESET_VEC & MTVEC_MASK;
      mepc        <= 32'd0;
      mcause      <= 32'd0;
    end else begin
      ext_sync_p0 <= irq_ext;
      tim_sync_p0 <= irq_timer;
      mip_meip    <= ext_sync_p0;
      mip_mtip    <= tim_sync_p0;
      if (take) begin
        mepc    <= bus.pc_mw & MEPC_MASK;
        mcause  <= {1'b1, 27'd0, cause};
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
        state   <= HANDLER;
      end else if (ret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
        state   <= IDLE;
      end else if (wr_en) begin
        case (bus.csr_addr)
          ADDR_MSTATUS: begin
            st_mie  <= new_val[3];
            st_mpie <= new_val[7];
          end
          ADDR_MIE: begin
            en_mtie <= new_val[7];
            en_meie <= new_val[11];
          end
          ADDR_MTVEC:  mtvec  <= new_val & MTVEC_MASK;
          ADDR_MEPC:   mepc   <= new_val & MEPC_MASK;
          ADDR_MCAUSE: mcause <= new_val;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_interrupt_ctrl.sv
module tb_csr_interrupt_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic irq_ext;
  logic irq_timer;

  always #5 clk = ~clk;

  csr_interrupt_ctrl_if bus ();

  csr_interrupt_ctrl #(.RESET_VEC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_ext   (irq_ext),
    .irq_timer (irq_timer),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        m;
    logic        w;
    logic [1:0]  op;
    logic [11:0] a;
    logic [31:0] d;
    logic        e;
    logic        t;
    logic [31:0] rd;
    logic [1:0]  it;
    logic [31:0] rpc;
    logic        ih;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [31:0] pc, logic m, logic w,
                              logic [1:0] op, logic [11:0] a, logic [31:0] d,
                              logic e, logic t, logic [31:0] rd, logic [1:0] it,
                              logic [31:0] rpc, logic ih);
    vec_t r;
    r.v = v; r.pc = pc; r.m = m; r.w = w; r.op = op; r.a = a; r.d = d;
    r.e = e; r.t = t; r.rd = rd; r.it = it; r.rpc = rpc; r.ih = ih;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic m,
                       input logic w, input logic [1:0] op, input logic [11:0] a,
                       input logic [31:0] d, input logic e, input logic t);
    bus.valid_mw  = v;
    bus.pc_mw     = pc;
    bus.is_mret   = m;
    bus.csr_wr    = w;
    bus.csr_op    = op;
    bus.csr_addr  = a;
    bus.csr_wdata = d;
    irq_ext       = e;
    irq_timer     = t;
  endtask

  // Reference model: CSRs as plain words, interrupt requests as a delay line.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
  logic        m_ih;
  logic        eh[2];
  logic        th[2];

  task automatic model_reset();
    m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_ih = 0;
    eh[0] = 0; eh[1] = 0; th[0] = 0; th[1] = 0;
  endtask

  function automatic logic [31:0] m_mip();
    return (eh[1] ? 32'h800 : 32'h0) | (th[1] ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h344: return m_mip();
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction

  logic [11:0] addrs[7] = '{12'h300, 12'h304, 12'h344, 12'h305, 12'h341, 12'h342, 12'h7C0};

  initial begin
    logic [31:0] pend, old, nv, exp_pc;
    logic        tk, rt;
    logic [3:0]  cs;
    logic        v, m, w, e, t;
    logic [1:0]  op;
    logic [11:0] a;
    logic [31:0] pc, d;

    rst = 1'b1;
    drive(0, 0, 0, 0, 2'b00, 12'h300, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // v, pc, mret, wr, op, addr, wdata, ext, tim | rdata, int, rpc, in_handler
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h300, 0, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h304, 0, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h344, 0, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h305, 0, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h341, 0, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h342, 0, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h10, 0, 1, 2'b01, 12'h304, 32'h880, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h14, 0, 1, 2'b11, 12'h304, 32'h080, 0, 0, 32'h880, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h304, 0, 0, 0, 32'h800, 0, 0, 0));
    tbl.push_back(mk(1, 32'h18, 0, 1, 2'b10, 12'h300, 32'h8, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h300, 0, 0, 0, 32'h8, 0, 0, 0));
    tbl.push_back(mk(1, 32'h1C, 0, 1, 2'b01, 12'h344, 32'hFFFF_FFFF, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h344, 0, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h20, 0, 1, 2'b01, 12'h305, 32'h100, 0, 0, 32'h0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h24, 0, 1, 2'b01, 12'h304, 32'h080, 0, 0, 32'h800, 0, 0, 0));
    // timer raised: visible in mip two edges later, blocked while valid_mw = 0
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h305, 0, 0, 1, 32'h100, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h344, 0, 0, 1, 32'h0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h40, 0, 0, 0, 12'h344, 0, 0, 1, 32'h80, 0, 0, 0));
    tbl.push_back(mk(1, 32'h40, 0, 0, 0, 12'h341, 0, 0, 1, 32'h0, 2'b01, 32'h100, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h342, 0, 0, 0, 32'h8000_0007, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h341, 0, 0, 0, 32'h40, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h300, 0, 0, 0, 32'h80, 0, 0, 1));
    tbl.push_back(mk(1, 32'h1000, 1, 0, 0, 12'h300, 0, 0, 0, 32'h80, 2'b10, 32'h40, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h300, 0, 0, 0, 32'h88, 0, 0, 0));
    // vectored mode; bit 1 of mtvec is not writable
    tbl.push_back(mk(1, 32'h50, 0, 1, 2'b01, 12'h305, 32'h203, 0, 0, 32'h100, 0, 0, 0));
    tbl.push_back(mk(1, 32'h54, 0, 1, 2'b01, 12'h304, 32'h880, 1, 1, 32'h80, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h305, 0, 1, 1, 32'h201, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h344, 0, 1, 1, 32'h880, 0, 0, 0));
    // trap beats an mret in the same instruction
    tbl.push_back(mk(1, 32'h80, 1, 0, 0, 12'h304, 0, 1, 1, 32'h880, 2'b01, 32'h22C, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h342, 0, 0, 0, 32'h8000_000B, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h341, 0, 0, 0, 32'h80, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h300, 0, 0, 0, 32'h80, 0, 0, 1));
    tbl.push_back(mk(1, 32'h90, 1, 0, 0, 12'h300, 0, 0, 0, 32'h80, 2'b10, 32'h80, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h300, 0, 1, 0, 32'h88, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h342, 0, 1, 0, 32'h8000_000B, 0, 0, 0));
    // trap beats a CSR write: mtvec write dropped
    tbl.push_back(mk(1, 32'hA0, 0, 1, 2'b01, 12'h305, 32'h400, 1, 0, 32'h201, 2'b01, 32'h22C, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h305, 0, 0, 0, 32'h201, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 12'h341, 0, 0, 0, 32'hA0, 0, 0, 1));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].pc, tbl[i].m, tbl[i].w, tbl[i].op, tbl[i].a,
            tbl[i].d, tbl[i].e, tbl[i].t);
      #1;
      chk($sformatf("row%0d_rdata", i), bus.csr_rdata, tbl[i].rd);
      chk($sformatf("row%0d_interrupt", i), {30'd0, bus.interrupt}, {30'd0, tbl[i].it});
      chk($sformatf("row%0d_redirect", i), {31'd0, bus.redirect}, {31'd0, tbl[i].it != 2'b00});
      chk($sformatf("row%0d_in_handler", i), {31'd0, bus.in_handler}, {31'd0, tbl[i].ih});
      if (tbl[i].it != 2'b00)
        chk($sformatf("row%0d_redirect_pc", i), bus.redirect_pc, tbl[i].rpc);
    end

    // Reset with a trap-worthy, writing instruction present: reset must win.
    @(negedge clk);
    rst = 1'b1;
    drive(1, 32'h300, 0, 1, 2'b01, 12'h341, 32'h1234, 1, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 12'h341, 0, 0, 0);
    #1;
    chk("reset_mepc", bus.csr_rdata, 32'h0);
    chk("reset_in_handler", {31'd0, bus.in_handler}, 32'h0);

    e = 0; t = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      v  = ($urandom_range(0, 3) != 0);
      m  = ($urandom_range(0, 9) == 0);
      w  = ($urandom_range(0, 1) == 1);
      op = 2'($urandom_range(0, 3));
      a  = addrs[$urandom_range(0, 6)];
      pc = $urandom;
      d  = ($urandom_range(0, 1) == 1) ? $urandom : (32'h888 & $urandom);
      if ($urandom_range(0, 9) == 0) e = ~e;
      if ($urandom_range(0, 9) == 0) t = ~t;
      drive(v, pc, m, w, op, a, d, e, t);
      #1;

      pend = m_mip() & m_mie;
      tk   = v && m_mstatus[3] && (pend != 0);
      cs   = pend[11] ? 4'd11 : 4'd7;
      rt   = v && m && !tk;
      exp_pc = tk ? ({m_mtvec[31:2], 2'b00} + (m_mtvec[0] ? 32'(cs) * 4 : 32'd0)) : m_mepc;
      chk($sformatf("rnd%0d_rdata", n), bus.csr_rdata, m_read(a));
      chk($sformatf("rnd%0d_interrupt", n), {30'd0, bus.interrupt},
          tk ? 32'd1 : (rt ? 32'd2 : 32'd0));
      chk($sformatf("rnd%0d_redirect", n), {31'd0, bus.redirect}, {31'd0, tk | rt});
      chk($sformatf("rnd%0d_in_handler", n), {31'd0, bus.in_handler}, {31'd0, m_ih});
      if (tk || rt)
        chk($sformatf("rnd%0d_redirect_pc", n), bus.redirect_pc, exp_pc);

      if (tk) begin
        m_mepc    = pc & 32'hFFFF_FFFC;
        m_mcause  = 32'h8000_0000 | 32'(cs);
        m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
        m_ih      = 1;
      end else if (rt) begin
        m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
        m_ih      = 0;
      end else if (v && w && op != 2'b00) begin
        old = m_read(a);
        nv  = (op == 2'b01) ? d : ((op == 2'b10) ? (old | d) : (old & ~d));
        case (a)
          12'h300: m_mstatus = nv & 32'h88;
          12'h304: m_mie     = nv & 32'h880;
          12'h305: m_mtvec   = nv & 32'hFFFF_FFFD;
          12'h341: m_mepc    = nv & 32'hFFFF_FFFC;
          12'h342: m_mcause  = nv;
          default: ;
        endcase
      end
      eh[1] = eh[0]; eh[0] = e;
      th[1] = th[0]; th[0] = t;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
